// File: rtl/ram64_stream_reader_pkg.sv
// ram64_stream_reader_pkg: RAM geometry and FSM state encodings shared by the stream reader.
package ram64_stream_reader_pkg;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/ram64_stream_reader_ctr.sv
// ram64_stream_reader_ctr: wrapping address counter and clamped remaining-word counter.
module ram64_stream_reader_ctr
  import ram64_stream_reader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
  logic [ADDR_W:0] rem;
  assign last = rem == (ADDR_W+1)'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= base;
      rem  <= len > DEPTH ? DEPTH : len;
    end else if (step) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
endmodule

// File: rtl/ram64_stream_reader.sv
// ram64_stream_reader: streams a wrapping window of the 64-word RAM onto a valid/ready port.
// Define RAM64_STREAM_READER_CHECKSUM_EN to accumulate a mod-2^16 sum of accepted words.
module ram64_stream_reader
  import ram64_stream_reader_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  state_t state, nxt;
  logic accept, step, hs, last, done_nxt;
  ram64_stream_reader_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .step (step),
    .base (base),
    .len  (len),
    .addr (mem_addr),
    .last (last)
  );
  assign mem_load = 1'b0;
  assign busy     = state != IDLE;
  always_comb begin
    hs       = m_valid && m_ready;
    accept   = state == IDLE && start && len != '0;
    step     = state == READ && (!m_valid || m_ready);
    done_nxt = (state == IDLE && start && len == '0) || (state == DRAIN && hs);
    nxt      = accept ? READ : (step && last) ? DRAIN : (state == DRAIN && hs) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      done  <= done_nxt;
      if (step) begin
        m_data  <= mem_rdata;
        m_valid <= 1'b1;
        m_last  <= last;
      end else if (state == DRAIN && hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (hs) checksum <= checksum + m_data;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_ram64_stream_reader.sv
// tb_ram64_stream_reader: random and directed runs checked against a queue-based reference model.
module tb_ram64_stream_reader;
  logic clk = 1'b0;
  logic rst_n, start, m_ready, mem_load, m_valid, m_last, busy, done;
  logic [5:0] base, mem_addr;
  logic [6:0] len;
  logic [15:0] mem_rdata, m_data, checksum;
  logic [15:0] ram [64];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr];

  ram64_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .mem_addr(mem_addr), .mem_load(mem_load), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_last"}, 32'(m_last), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_csum"}, 32'(checksum), 0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1,...
  task automatic run(input logic [5:0] b, input logic [6:0] l, input int mode);
    logic [15:0] q [$];
    logic [15:0] sum, d, e;
    logic v, lst, r;
    int n, k, beats;
    n = l > 7'd64 ? 64 : int'(l);
    for (int i = 0; i < n; i++) q.push_back(ram[(int'(b) + i) % 64]);
    sum = '0;
    base = b; len = l; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(n != 0));
    if (n == 0) begin
      chk("done_len0", 32'(done), 1);
      chk("valid_len0", 32'(m_valid), 0);
      @(posedge clk); #1;
      chk("done_len0_once", 32'(done), 0);
      chk("valid_len0_later", 32'(m_valid), 0);
      return;
    end
    chk("addr_after_start", 32'(mem_addr), 32'(b));
    k = 0; beats = 0;
    while (!done && k < 400) begin
      r = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (k % 4 == 0 || k % 4 == 3);
      m_ready = r; v = m_valid; d = m_data; lst = m_last;
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1; base = 6'($urandom); len = 7'($urandom);
      end else start = 1'b0;
      @(posedge clk); #1;
      k++;
      chk("mem_load", 32'(mem_load), 0);
      if (v && r) begin
        beats++;
        sum += d;
        if (q.size() == 0) chk("extra_beat", 32'(beats), 32'(n));
        else begin
          e = q.pop_front();
          chk("beat_data", 32'(d), 32'(e));
          chk("beat_last", 32'(lst), 32'(q.size() == 0));
        end
      end else if (v) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(d));
        chk("stall_last", 32'(m_last), 32'(lst));
      end
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    chk("beat_count", 32'(beats), 32'(n));
    chk("words_left", 32'(q.size()), 0);
    chk("busy_at_done", 32'(busy), 0);
    chk("valid_at_done", 32'(m_valid), 0);
    if (mode == 0) chk("run_latency", 32'(k), 32'(n + 1));
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(sum));
`else
    chk("checksum_off", 32'(checksum), 0);
`endif
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 0);
  endtask

  initial begin
    logic v;
    int beats, k;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; base = '0; len = '0;
    for (int i = 0; i < 64; i++) ram[i] = 16'(i * 3);
    #3;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(6'd0, 7'd64, 0);
    run(6'd62, 7'd4, 0);
    run(6'd10, 7'd5, 2);
    run(6'd7, 7'd0, 0);
    run(6'd20, 7'd100, 0);
    base = 6'd0; len = 7'd10; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; beats = 0; k = 0;
    while (beats < 3 && k < 50) begin
      v = m_valid;
      @(posedge clk); #1;
      if (v) beats++;
      k++;
    end
    chk("beats_before_abort", 32'(beats), 3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(6'd5, 7'd3, 0);
    ram[0] = 16'hFFFF; ram[1] = 16'h0002; ram[2] = 16'h1000; ram[3] = 16'h0001;
    run(6'd0, 7'd4, 0);
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
    chk("checksum_known", 32'(checksum), 32'h1002);
`else
    chk("checksum_known_off", 32'(checksum), 0);
`endif
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
      run(6'($urandom), 7'($urandom), t % 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
